// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles 12-bit instructions and drives the
// program memory load port. Define PROG_LOADER_CHECKSUM_EN for the XOR trailer check.
module prog_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        LE,
    output logic [7:0]  LA,
    output logic [11:0] LI,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd5;
`endif

    logic [2:0] state;
    logic [7:0] addr;
    logic [8:0] remaining;
    logic [3:0] hi_nib;
    logic       xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    // Ready is a pure decode of state, so it drops for the whole WRITE cycle.
`ifdef PROG_LOADER_CHECKSUM_EN
    assign rx_ready = (state == S_COUNT) || (state == S_HI) ||
                      (state == S_LO) || (state == S_CSUM);
`else
    assign rx_ready = (state == S_COUNT) || (state == S_HI) || (state == S_LO);
`endif
    assign xfer = rx_valid && rx_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr      <= 8'h00;
            remaining <= 9'd0;
            hi_nib    <= 4'h0;
            LE        <= 1'b0;
            LA        <= 8'h00;
            LI        <= 12'h000;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= 8'h00;
`endif
        end else if (state == S_IDLE) begin
            if (start) begin
                state <= S_COUNT;
                busy  <= 1'b1;
                done  <= 1'b0;
                err   <= 1'b0;
                addr  <= BASE_ADDR;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum  <= 8'h00;
`endif
            end
        end else if (abort) begin
            // Abort beats any byte handshaking in the same cycle.
            state <= S_IDLE;
            LE    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b1;
        end else begin
            case (state)
                S_COUNT: if (xfer) begin
                    remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    state     <= S_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum      <= csum ^ rx_data;
`endif
                end
                S_HI: if (xfer) begin
                    hi_nib <= rx_data[3:0];
                    state  <= S_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum   <= csum ^ rx_data;
`endif
                end
                S_LO: if (xfer) begin
                    LI    <= {hi_nib, rx_data};
                    LA    <= addr;
                    LE    <= 1'b1;
                    state <= S_WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum  <= csum ^ rx_data;
`endif
                end
                S_WRITE: begin
                    LE        <= 1'b0;
                    addr      <= addr + 8'd1;
                    remaining <= remaining - 9'd1;
                    if (remaining == 9'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state <= S_CSUM;
`else
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end else begin
                        state <= S_HI;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CSUM: if (xfer) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    err   <= (rx_data != csum);
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
